// File: rtl/vec_mac_pkg.sv
// Shared types and fp32 helpers for the vector MAC: scalar lane format plus
// round-to-nearest-even add/multiply (subnormals flush to zero).
package vec_mac_pkg;

  localparam int SINGLE    = 32;
  localparam int MAX_LANES = 16;

  typedef struct packed {
    logic [SINGLE-1:0] value;
    logic              valid;
  } scalar_t;

  localparam int SCALAR_W = $bits(scalar_t);

  typedef scalar_t [MAX_LANES-1:0] scalar_vec_t;

  localparam logic [SINGLE-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [SINGLE-1:0] FP32_QNAN = 32'h7FC0_0000;

  // e_in is the biased exponent of a significand normalised as 1.frac.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e_in,
                                          input logic [22:0] frac, input logic g, input logic st);
    logic [24:0]        sig;
    logic signed [10:0] e;
    e   = e_in;
    sig = {2'b01, frac} + {24'b0, (g & (st | frac[0]))};
    if (sig[24]) e = e + 11'sd1;
    if (e >= 11'sd255) return {s, 8'hFF, 23'b0};
    if (e <= 11'sd0)   return {s, 31'b0};
    return {s, e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        prod;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
      return FP32_QNAN;
    if (a[30:23] == 8'hFF) return (b[30:23] == 8'h00) ? FP32_QNAN : {s, 8'hFF, 23'b0};
    if (b[30:23] == 8'hFF) return (a[30:23] == 8'h00) ? FP32_QNAN : {s, 8'hFF, 23'b0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
    prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e    = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
    if (prod[47]) return fp_pack(s, e + 11'sd1, prod[46:24], prod[23], |prod[22:0]);
    return fp_pack(s, e, prod[45:23], prod[22], |prod[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [7:0]         d;
    logic [49:0]        bx, sx;
    logic [50:0]        s, n;
    logic [5:0]         lz;
    logic signed [10:0] e;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
      return FP32_QNAN;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] != b[31]) ? FP32_QNAN : a;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'b0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    d  = x[30:23] - y[30:23];
    bx = {1'b1, x[22:0], 26'b0};
    sx = {1'b1, y[22:0], 26'b0};
    // Beyond 26 places the smaller operand only matters as a sticky bit.
    if (d > 8'd49)      sx = 50'd1;
    else if (d > 8'd26) sx = (sx >> d) | 50'd1;
    else                sx = sx >> d;
    s = (x[31] == y[31]) ? ({1'b0, bx} + {1'b0, sx}) : ({1'b0, bx} - {1'b0, sx});
    if (s == '0) return FP32_ZERO;
    lz = '0;
    for (int i = 0; i < 51; i++) if (s[i]) lz = 6'(50 - i);
    n = s << lz;
    e = $signed({3'b0, x[30:23]}) + 11'sd1 - $signed({5'b0, lz});
    return fp_pack(x[31], e, n[49:27], n[26], |n[25:0]);
  endfunction

endpackage

// File: rtl/vec_mac_tree.sv
// Pairwise fp32 reduction by lane index: lower half and upper half are reduced
// recursively, then summed. Purely combinational.
module vec_mac_tree
  import vec_mac_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES*SINGLE-1:0] vals_i,
  output logic [SINGLE-1:0]       sum_o
);

  if (LANES == 1) begin : g_leaf
    assign sum_o = vals_i;
  end else begin : g_node
    localparam int HALF = LANES / 2;
    logic [SINGLE-1:0] lo_sum, hi_sum;

    vec_mac_tree #(.LANES(HALF)) u_lo (
      .vals_i (vals_i[HALF*SINGLE-1:0]),
      .sum_o  (lo_sum)
    );
    vec_mac_tree #(.LANES(HALF)) u_hi (
      .vals_i (vals_i[LANES*SINGLE-1:HALF*SINGLE]),
      .sum_o  (hi_sum)
    );

    assign sum_o = fp_add(lo_sum, hi_sum);
  end

endmodule

// File: rtl/vec_mac.sv
// Vector fp32 multiply-accumulate: product reg -> tree reg -> accumulator -> output reg.
// Last beat accepted at edge N gives out_valid after edge N+3; one pending vector at a time.
module vec_mac
  import vec_mac_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int RELU_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_last_i,
  input  logic [LANES*SCALAR_W-1:0] data_i,
  input  logic [LANES*SCALAR_W-1:0] weight_i,
  input  logic                     relu_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [SINGLE-1:0]        out_o
);

  typedef scalar_t [LANES-1:0] lane_vec_t;
  localparam logic RELU_ON = (RELU_EN != 0);

  lane_vec_t                data_v, weight_v;
  logic [LANES*SINGLE-1:0]  prod_d, p_prod_q;
  logic                     p_vld_q, p_last_q, p_relu_q;
  logic [SINGLE-1:0]        tree_sum, t_sum_q;
  logic                     t_vld_q, t_last_q, t_relu_q;
  logic [SINGLE-1:0]        acc_d, acc_q;
  logic                     a_vld_q, a_last_q, a_relu_q, first_q;
  logic [SINGLE-1:0]        out_d, out_q;
  logic                     out_vld_d, out_vld_q, busy_d, busy_q, accept, out_hs;

  assign data_v      = data_i;
  assign weight_v    = weight_i;
  assign in_ready_o  = !busy_q;
  assign accept      = in_valid_i && in_ready_o;
  assign out_hs      = out_vld_q && out_ready_i;
  assign out_valid_o = out_vld_q;
  assign out_o       = out_q;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++)
      if (data_v[i].valid && weight_v[i].valid)
        prod_d[i*SINGLE +: SINGLE] = fp_mul(data_v[i].value, weight_v[i].value);
  end

  vec_mac_tree #(.LANES(LANES)) u_tree (
    .vals_i (p_prod_q),
    .sum_o  (tree_sum)
  );

  always_comb begin
    acc_d     = fp_add(first_q ? FP32_ZERO : acc_q, t_sum_q);
    out_d     = out_q;
    out_vld_d = out_vld_q;
    busy_d    = busy_q;
    if (a_vld_q && a_last_q) begin
      out_d     = (a_relu_q && acc_q[SINGLE-1]) ? FP32_ZERO : acc_q;
      out_vld_d = 1'b1;
    end else if (out_hs) begin
      out_vld_d = 1'b0;
    end
    // Input stays closed from the last beat until its result leaves.
    if (accept && in_last_i) busy_d = 1'b1;
    else if (out_hs)         busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld_q   <= 1'b0;
      p_prod_q  <= '0;
      p_last_q  <= 1'b0;
      p_relu_q  <= 1'b0;
      t_vld_q   <= 1'b0;
      t_sum_q   <= FP32_ZERO;
      t_last_q  <= 1'b0;
      t_relu_q  <= 1'b0;
      a_vld_q   <= 1'b0;
      a_last_q  <= 1'b0;
      a_relu_q  <= 1'b0;
      acc_q     <= FP32_ZERO;
      first_q   <= 1'b1;
      out_q     <= FP32_ZERO;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      p_vld_q <= accept;
      if (accept) begin
        p_prod_q <= prod_d;
        p_last_q <= in_last_i;
        p_relu_q <= relu_i & RELU_ON;
      end
      t_vld_q <= p_vld_q;
      if (p_vld_q) begin
        t_sum_q  <= tree_sum;
        t_last_q <= p_last_q;
        t_relu_q <= p_relu_q;
      end
      a_vld_q <= t_vld_q;
      if (t_vld_q) begin
        acc_q    <= acc_d;
        first_q  <= t_last_q;
        a_last_q <= t_last_q;
        a_relu_q <= t_relu_q;
      end
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_vec_mac.sv
// Directed bench for vec_mac (LANES=4, ReLU built): expected dot products are
// queued when a vector is driven and compared when the result is presented.
module tb_vec_mac;
  import vec_mac_pkg::*;

  localparam int LANES = 4;
  localparam logic [31:0] F5  = 32'h40A0_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] FM2 = 32'hC000_0000;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid, in_ready, in_last, relu;
  logic [LANES*SCALAR_W-1:0] data, weight;
  logic                      out_valid, out_ready;
  logic [31:0]               out;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  vec_mac #(.LANES(LANES), .RELU_EN(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_last_i   (in_last),
    .data_i      (data),
    .weight_i    (weight),
    .relu_i      (relu),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_o       (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one beat at posedge+1 and returns at the next posedge+1.
  task automatic send_beat(input string tag, input logic [127:0] dv, input logic [127:0] wv,
                           input logic [3:0] dm, input logic [3:0] wm,
                           input logic last, input logic rl);
    for (int k = 0; k < LANES; k++) begin
      data[k*SCALAR_W +: SCALAR_W]   = {dv[k*32 +: 32], dm[k]};
      weight[k*SCALAR_W +: SCALAR_W] = {wv[k*32 +: 32], wm[k]};
    end
    in_valid = 1'b1;
    in_last  = last;
    relu     = rl;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string tag);
    int          cyc;
    logic [31:0] exp;
    cyc      = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    relu     = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd3);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_out"}, out, exp);
    check({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_rdy_rise"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    relu      = 1'b0;
    out_ready = 1'b0;
    data      = '0;
    weight    = '0;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", out, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4 x (5*5) in one beat
    exp_q.push_back(32'h42C8_0000);
    send_beat("v1", {4{F5}}, {4{F5}}, 4'hF, 4'hF, 1'b1, 1'b0);
    wait_result("v1");
    handshake("v1");

    // two back-to-back beats
    exp_q.push_back(32'h4348_0000);
    send_beat("v2a", {4{F5}}, {4{F5}}, 4'hF, 4'hF, 1'b0, 1'b0);
    send_beat("v2b", {4{F5}}, {4{F5}}, 4'hF, 4'hF, 1'b1, 1'b0);
    wait_result("v2");
    handshake("v2");

    // lanes 1 and 3 masked on data
    exp_q.push_back(32'h4248_0000);
    send_beat("v3", {4{F5}}, {4{F5}}, 4'b0101, 4'hF, 1'b1, 1'b0);
    wait_result("v3");
    handshake("v3");

    // -2*3 + 1*1 = -5, clamped by relu
    exp_q.push_back(32'h0000_0000);
    send_beat("v4", {32'h0, 32'h0, F1, FM2}, {32'h0, 32'h0, F1, F3}, 4'hF, 4'hF, 1'b1, 1'b1);
    wait_result("v4");
    handshake("v4");

    exp_q.push_back(32'hC0A0_0000);
    send_beat("v5", {32'h0, 32'h0, F1, FM2}, {32'h0, 32'h0, F1, F3}, 4'hF, 4'hF, 1'b1, 1'b0);
    wait_result("v5");
    held = out;

    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_out", out, held);
      check("hold_vld", {31'b0, out_valid}, 32'd1);
      check("hold_busy", {31'b0, in_ready}, 32'd0);
    end
    handshake("v5");

    // next vector must be accepted on the very next cycle
    exp_q.push_back(32'h42C8_0000);
    send_beat("v6", {4{F5}}, {4{F5}}, 4'hF, 4'hF, 1'b1, 1'b0);
    wait_result("v6");
    handshake("v6");

    // abort after first beat of a 3-beat vector
    send_beat("v7a", {4{F5}}, {4{F5}}, 4'hF, 4'hF, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h4180_0000);
    send_beat("v8", {4{F2}}, {4{F2}}, 4'hF, 4'hF, 1'b1, 1'b0);
    wait_result("v8");
    handshake("v8");

    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
